// File: rtl/multi_nch_disp.sv
// N-channel seven-segment display multiplexer with a registered channel-0
// word, manual select and masked auto-scan on a fixed dwell.
module multi_nch_disp #(
  parameter int CH    = 8,
  parameter int DW    = 32,
  parameter int PW    = DW / 4,
  parameter int DWELL = 4,
  parameter int SW    = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             auto,
  input  logic [SW-1:0]    Test,
  input  logic [CH-1:0]    mask,
  input  logic [CH*DW-1:0] data_in,
  input  logic [CH*PW-1:0] point_in,
  input  logic [CH*PW-1:0] LES,
  output logic [DW-1:0]    Disp_num,
  output logic [PW-1:0]    point_out,
  output logic [PW-1:0]    LE_out,
  output logic [SW-1:0]    cur_ch,
  output logic             ch_tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  logic [DW-1:0] ch0_reg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [SW-1:0] sel_next;
  logic [SW-1:0] nxt_masked;
  logic [SW-1:0] cand;
  logic          found;
  logic          tick_next;
  logic [DW-1:0] word_next;
  logic [PW-1:0] point_next;
  logic [PW-1:0] le_next;

  // Upward search from cur_ch; the last candidate is cur_ch itself.
  always_comb begin
    nxt_masked = cur_ch;
    cand       = cur_ch;
    found      = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      cand = cur_ch + SW'(i);
      if (!found && mask[cand]) begin
        nxt_masked = cand;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    sel_next  = cur_ch;
    cnt_next  = '0;
    tick_next = 1'b0;
    if (!auto) begin
      sel_next = Test;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CW'(1);
    end else if (found) begin
      sel_next  = nxt_masked;
      tick_next = 1'b1;
    end else begin
      sel_next = '0;
    end
  end

  always_comb begin
    word_next  = data_in[int'(sel_next)*DW +: DW];
    point_next = point_in[int'(sel_next)*PW +: PW];
    le_next    = LES[int'(sel_next)*PW +: PW];
    if (sel_next == '0) word_next = ch0_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch0_reg   <= '0;
      cnt       <= '0;
      cur_ch    <= '0;
      ch_tick   <= 1'b0;
      Disp_num  <= '0;
      point_out <= '0;
      LE_out    <= '0;
    end else begin
      if (EN) ch0_reg <= data_in[DW-1:0];
      cnt       <= cnt_next;
      cur_ch    <= sel_next;
      ch_tick   <= tick_next;
      Disp_num  <= word_next;
      point_out <= point_next;
      LE_out    <= le_next;
    end
  end

endmodule

// File: tb/tb_multi_nch_disp.sv
// Scoreboard bench for multi_nch_disp: a cycle model predicts each edge,
// results are queued and compared after the edge.
module tb_multi_nch_disp;

  localparam int CH    = 8;
  localparam int DW    = 32;
  localparam int PW    = 8;
  localparam int DWELL = 4;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             EN;
  logic             auto;
  logic [SW-1:0]    Test;
  logic [CH-1:0]    mask;
  logic [CH*DW-1:0] data_in;
  logic [CH*PW-1:0] point_in;
  logic [CH*PW-1:0] LES;
  logic [DW-1:0]    Disp_num;
  logic [PW-1:0]    point_out;
  logic [PW-1:0]    LE_out;
  logic [SW-1:0]    cur_ch;
  logic             ch_tick;

  multi_nch_disp #(
    .CH(CH), .DW(DW), .PW(PW), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .EN(EN), .auto(auto),
    .Test(Test), .mask(mask), .data_in(data_in),
    .point_in(point_in), .LES(LES),
    .Disp_num(Disp_num), .point_out(point_out),
    .LE_out(LE_out), .cur_ch(cur_ch), .ch_tick(ch_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] ch;
    logic [DW-1:0] word;
    logic [PW-1:0] pt;
    logic [PW-1:0] le;
    logic          tick;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          m_cur;
  int          m_cnt;
  logic [31:0] m_ch0;
  int          tick_seq[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 0;
    m_cnt = 0;
    m_ch0 = '0;
  endtask

  // Predict one edge from the current inputs, then compare after it.
  task automatic step();
    exp_t e;
    exp_t o;
    int   nxt;
    int   ncnt;
    logic ntick;
    ntick = 1'b0;
    ncnt  = 0;
    if (!auto) begin
      nxt = int'(Test);
    end else if (m_cnt < DWELL - 1) begin
      nxt  = m_cur;
      ncnt = m_cnt + 1;
    end else if (mask == '0) begin
      nxt = 0;
    end else begin
      nxt = m_cur;
      do nxt = (nxt + 1) % CH; while (!mask[nxt]);
      ntick = 1'b1;
    end
    e.ch   = SW'(nxt);
    e.word = (nxt == 0) ? m_ch0 : data_in[nxt*DW +: DW];
    e.pt   = point_in[nxt*PW +: PW];
    e.le   = LES[nxt*PW +: PW];
    e.tick = ntick;
    q.push_back(e);
    if (EN) m_ch0 = data_in[31:0];
    m_cur = nxt;
    m_cnt = ncnt;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      o = q.pop_front();
      check("cur_ch", 64'(cur_ch), 64'(o.ch));
      check("Disp_num", 64'(Disp_num), 64'(o.word));
      check("point_out", 64'(point_out), 64'(o.pt));
      check("LE_out", 64'(LE_out), 64'(o.le));
      check("ch_tick", 64'(ch_tick), 64'(o.tick));
      if (ch_tick) tick_seq.push_back(int'(cur_ch));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_disp"}, 64'(Disp_num), 64'd0);
    check({tag, "_pt"}, 64'(point_out), 64'd0);
    check({tag, "_le"}, 64'(LE_out), 64'd0);
    check({tag, "_ch"}, 64'(cur_ch), 64'd0);
    check({tag, "_tick"}, 64'(ch_tick), 64'd0);
  endtask

  initial begin
    int exp_seq[4] = '{2, 7, 0, 2};
    rst      = 1'b1;
    EN       = 1'b0;
    auto     = 1'b0;
    Test     = 3'd3;
    mask     = 8'hFF;
    data_in  = {32'h20170314, 32'hFFFFFFFF, 32'h00000000, 32'h21474836,
                32'h55AAAA55, 32'hAA5555AA, 32'h87654321, 32'hCAFEF00D};
    point_in = 64'hAA5555AAAA5555AA;
    LES      = 64'h0123456789ABCDEF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < CH; t++) begin
      Test = SW'(t);
      step();
    end
    Test = 3'd0;
    step();
    check("ch0_initial", 64'(Disp_num), 64'h0);

    data_in[31:0] = 32'h12345678;
    EN = 1'b1;
    step();
    check("ch0_old_word", 64'(Disp_num), 64'h0);
    EN = 1'b0;
    step();
    check("ch0_new_word", 64'(Disp_num), 64'h12345678);
    data_in[31:0] = 32'hDEADBEEF;
    repeat (2) step();
    check("ch0_hold", 64'(Disp_num), 64'h12345678);

    auto = 1'b1;
    mask = 8'hFF;
    repeat (DWELL * 9) step();

    mask = 8'b1000_0101;
    tick_seq.delete();
    repeat (DWELL * 4) step();
    check("masked_ticks", 64'(tick_seq.size()), 64'd4);
    for (int i = 0; i < 4 && i < tick_seq.size(); i++)
      check("masked_seq", 64'(tick_seq[i]), 64'(exp_seq[i]));

    mask = 8'h00;
    repeat (DWELL) step();
    check("mask0_ch", 64'(cur_ch), 64'd0);

    mask = 8'b1000_0101;
    repeat (DWELL) step();
    check("on_ch2", 64'(cur_ch), 64'd2);
    auto = 1'b0;
    Test = 3'd5;
    step();
    check("manual_ch5", 64'(cur_ch), 64'd5);
    auto = 1'b1;
    repeat (DWELL * 2) step();

    mask = 8'h80;
    repeat (DWELL * 2) step();

    mask = 8'hFF;
    repeat (DWELL + 2) step();
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    q.delete();
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b0;
    mask = 8'b1000_0101;
    repeat (DWELL * 3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/multi_nch_disp.md
# multi_nch_disp

Parametrised N-channel display multiplexer: the next generation of the 8-channel, 32-bit display selector. It selects one of CH data words, together with that channel's decimal-point and blank-enable fields, for the seven-segment display driver. Channel 0 is held in a load-enabled register. A new auto-scan mode rotates through a masked set of channels on a programmable dwell, and all outputs are registered.

## Interface
- CH, 8: channel count; ≥2, power of two.
- DW, 32: data word width per channel; multiple of 4.
- PW, DW/4: point/LE field width per channel (one bit per hex digit).
- DWELL, 4: cycles each channel is shown in auto mode; ≥1.
- SW, $clog2(CH): channel-select width (derived).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- EN  in  1  load enable for the channel-0 register.
- auto  in  1  0 = manual select via Test; 1 = auto-scan.
- Test  in  SW  manual channel select.
- mask  in  CH  auto-scan enable per channel; bit i = 1 includes channel i.
- data_in  in  CH*DW  channel words; channel i is bits [i*DW +: DW].
- point_in  in  CH*PW  decimal-point fields, packed in the same way.
- LES  in  CH*PW  blank-enable fields, packed in the same way.
- Disp_num  out  DW  selected data word (registered).
- point_out  out  PW  selected point field (registered).
- LE_out  out  PW  selected LE field (registered).
- cur_ch  out  SW  channel currently shown (registered).
- ch_tick  out  1  one-cycle pulse on an auto-mode channel advance.

## Operation
- ch0_reg (DW bits): loads data_in[DW-1:0] on any edge with EN=1, otherwise holds. Channel 0 presents ch0_reg, not the live input. Channels 1..CH-1 present data_in directly. The point and LE fields are always taken live for every channel.
- sel_next selects the channel for the next cycle:
  - manual (auto=0): sel_next = Test, and the dwell counter is held at 0.
  - auto (auto=1): the dwell counter counts 0..DWELL-1.
  - When the counter is below DWELL-1: sel_next = cur_ch and the counter increments.
  - When the counter equals DWELL-1: the counter returns to 0 and sel_next becomes the next channel above cur_ch with mask=1, searching upward and wrapping from CH-1 to 0. ch_tick is set to 1 for that cycle.
  - If cur_ch is the only channel with mask=1, sel_next = cur_ch and ch_tick still pulses.
  - If mask == 0: sel_next = 0, ch_tick stays 0, and the counter keeps cycling.
- Mode switch from manual to auto: the counter starts at 0 and scanning begins from the current cur_ch. cur_ch is shown for a full DWELL before the first advance, and is shown even if its mask bit is 0.
- Mode switch from auto to manual: cur_ch = Test on the next edge, and the counter is cleared.
- On every edge: cur_ch ← sel_next, and {Disp_num, point_out, LE_out} ← fields of channel sel_next. The channel-0 word used is the pre-edge ch0_reg value.

## Timing
- Reset (asynchronous, rst=1): cur_ch=0, counter=0, ch0_reg=0, Disp_num=0, point_out=0, LE_out=0, ch_tick=0. All are held while rst=1.
- After rst is released, the first edge loads outputs per the rules above.
- Manual latency: a Test change before edge k appears on cur_ch and the outputs after edge k (1 cycle).
- Channel 0 load: EN=1 at edge k updates ch0_reg. With channel 0 selected, Disp_num shows the new word after edge k+1. A simultaneous EN and selection at edge k shows the old word.
- Auto: each channel is shown for exactly DWELL cycles. ch_tick is high during the first cycle a new cur_ch is visible.
- DWELL=1: the channel advances every edge, and ch_tick is constantly 1 while two or more channels are enabled.
- A mask change takes effect at the next advance and never truncates the current dwell.
- Reset mid-scan returns to channel 0 with the counter at 0. Auto mode then resumes from channel 0.

## Test plan
- Reset/manual: hold rst, check all outputs are 0. Release with CH=8, DW=32, data_in words 1..7 = 87654321, AA5555AA, 55AAAA55, 21474836, 00000000, FFFFFFFF, 20170314, point_in=64'hAA5555AAAA5555AA. Sweep Test 0..7: after each edge, Disp_num, point_out and cur_ch match that channel, and channel 0 reads 00000000.
- EN load: data_in[31:0]=12345678, EN=1 for one cycle with Test=0. Disp_num stays 00000000 for one cycle, then reads 12345678. Change data_in[31:0] with EN=0: Disp_num holds 12345678.
- Auto full scan: DWELL=4, mask=8'hFF, auto=1. cur_ch steps 0→1→…→7→0, with 4 cycles per channel and ch_tick high on each step's first cycle.
- Auto masked with wrap: mask=8'b1000_0101. The sequence is 0→2→7→0→2, and masked channels never appear. Then set mask=0: cur_ch goes to 0 with no tick.
- Mode switch: during auto on channel 2, set auto=0 with Test=5. cur_ch=5 after 1 edge. Set auto=1: channel 5 is held for 4 cycles, then advances.
- Async reset mid-scan: assert rst between edges. Outputs and cur_ch go to 0 immediately, without waiting for a clock edge.
